// File: rtl/quant_pkg.sv
// quant_pkg: shared width defaults, FSM state type and accumulator-width helper
// for the quantizer family. No ports; imported by quant_err_sq and quant_err_accum.
package quant_pkg;

    localparam int QUANT_WIDTH = 32;

    typedef enum logic {
        ACCUM,
        RESULT
    } accum_state_t;

    // Wide enough to sum len full-precision squares of width-bit values without wrap.
    function automatic int acc_width(input int width, input int len);
        return 2 * width + $clog2(len);
    endfunction

endpackage

// File: rtl/quant_err_sq.sv
// quant_err_sq: two-stage |y - y_hat| / square pipeline with valid passthrough.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid           accepted sample pair strobe (already qualified by ready)
//   y, y_hat           unquantized sample and quantizer output
//   out_valid          stage-2 valid
//   err                stage-2 absolute error
//   neg                stage-2 flag: y_hat > y
//   sq                 stage-2 full-precision err*err
module quant_err_sq
    import quant_pkg::*;
#(
    parameter int WIDTH = QUANT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     y,
    input  logic [WIDTH-1:0]     y_hat,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     err,
    output logic                 neg,
    output logic [2*WIDTH-1:0]   sq
);

    logic [WIDTH-1:0] err1;
    logic             neg1;
    logic             valid1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid1    <= 1'b0;
            err1      <= '0;
            neg1      <= 1'b0;
            out_valid <= 1'b0;
            err       <= '0;
            neg       <= 1'b0;
            sq        <= '0;
        end else begin
            valid1    <= in_valid;
            if (in_valid) begin
                err1 <= (y >= y_hat) ? y - y_hat : y_hat - y;
                neg1 <= y_hat > y;
            end
            out_valid <= valid1;
            if (valid1) begin
                err <= err1;
                neg <= neg1;
                sq  <= (2*WIDTH)'(err1) * (2*WIDTH)'(err1);
            end
        end
    end

endmodule

// File: rtl/quant_err_accum.sv
// quant_err_accum: per-block sum of squared error, peak |error| and sign-violation flag.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_ready  sample pair handshake
//   y, y_hat            unquantized sample and quantizer output
//   out_valid, out_ready block result handshake (held until accepted)
//   sse                 sum of squared errors over the block
//   max_err             peak |y - y_hat| over the block
//   neg_seen            at least one sample had y_hat > y
module quant_err_accum
    import quant_pkg::*;
#(
    parameter int WIDTH     = QUANT_WIDTH,
    parameter int BLOCK_LEN = 256,
    parameter int CNT_W     = $clog2(BLOCK_LEN) + 1,
    parameter int ACC_W     = acc_width(WIDTH, BLOCK_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   y,
    input  logic [WIDTH-1:0]   y_hat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   sse,
    output logic [WIDTH-1:0]   max_err,
    output logic               neg_seen
);

    localparam logic [CNT_W-1:0] LEN = CNT_W'(BLOCK_LEN);

    accum_state_t        state, state_nx;
    logic [CNT_W-1:0]    in_cnt, done_cnt;
    logic [ACC_W-1:0]    acc;
    logic [WIDTH-1:0]    max_r;
    logic                neg_r;
    logic                take;
    logic                s2_valid;
    logic [WIDTH-1:0]    s2_err;
    logic                s2_neg;
    logic [2*WIDTH-1:0]  s2_sq;

    assign take = in_valid & in_ready;

    quant_err_sq #(.WIDTH(WIDTH)) u_sq (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (take),
        .y         (y),
        .y_hat     (y_hat),
        .out_valid (s2_valid),
        .err       (s2_err),
        .neg       (s2_neg),
        .sq        (s2_sq)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nx;
    end

    // Intake closes after BLOCK_LEN pairs so the next block never enters the
    // pipeline while the current result is still pending.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = in_cnt < LEN;
                if (s2_valid && done_cnt == LEN - 1'b1) state_nx = RESULT;
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ACCUM;
            end
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (out_valid && out_ready)) begin
            acc      <= '0;
            max_r    <= '0;
            neg_r    <= 1'b0;
            in_cnt   <= '0;
            done_cnt <= '0;
        end else begin
            if (take) in_cnt <= in_cnt + 1'b1;
            if (s2_valid) begin
                acc      <= acc + ACC_W'(s2_sq);
                max_r    <= (s2_err > max_r) ? s2_err : max_r;
                neg_r    <= neg_r | s2_neg;
                done_cnt <= done_cnt + 1'b1;
            end
        end
    end

    assign sse      = acc;
    assign max_err  = max_r;
    assign neg_seen = neg_r;

endmodule

// File: doc/quant_err_accum.md
# quant_err_accum

Block-level quantization-error accumulator, directly downstream of the quantizer stage. It consumes a stream of (Y, Y_hat) sample pairs, computes the per-sample absolute error and its square, and accumulates over a fixed-length block. Once per block it emits the sum of squared errors, the peak absolute error and a sign-violation flag for MSE/SQNR reporting. Sample intake is valid/ready; result output is valid/ready with backpressure.

## Interface
- WIDTH, 32: sample width of Y and Y_hat.
- BLOCK_LEN, 256: samples per block; power of two, ≥ 2.
- CNT_W, $clog2(BLOCK_LEN)+1: sample counter width (derived).
- ACC_W, 2*WIDTH+$clog2(BLOCK_LEN): accumulator width (derived); never overflows.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  sample pair valid.
- in_ready  out  1  block can accept a pair.
- y  in  WIDTH  unquantized sample Y.
- y_hat  in  WIDTH  quantizer output Y_hat.
- out_valid  out  1  block result valid.
- out_ready  in  1  consumer accepts result.
- sse  out  ACC_W  sum of squared errors over the block.
- max_err  out  WIDTH  peak |Y − Y_hat| over the block.
- neg_seen  out  1  at least one sample had Y_hat > Y.

## Operation
- Unsigned arithmetic throughout. err = (y ≥ y_hat) ? y − y_hat : y_hat − y; neg = (y_hat > y).
- Stage 1 (S1): registers err, neg, valid on input handshake (in_valid & in_ready).
- Stage 2 (S2): registers sq = err*err (2*WIDTH bits, full precision), err, neg, valid.
- Accumulate on S2 valid: acc += sq; max_r = max(max_r, err); neg_r |= neg; done_cnt++.
- FSM states:
  - ACCUM: in_ready = 1 while in_cnt < BLOCK_LEN. in_cnt increments per accepted pair. When done_cnt reaches BLOCK_LEN → RESULT.
  - RESULT: out_valid = 1; sse/max_err/neg_seen driven from acc/max_r/neg_r and held stable. On out_valid & out_ready: clear acc, max_r, neg_r, in_cnt, done_cnt; → ACCUM.
- in_ready = 0 once BLOCK_LEN pairs are accepted, until the result handshake completes. No samples of the next block enter the pipeline early.
- Inputs while in_ready = 0 are ignored; y/y_hat need not be held stable when in_valid = 0.

## Timing
- Reset (rst_n = 0 at a clk edge): state ACCUM; in_ready = 1 the following cycle; out_valid = 0; sse = 0; max_err = 0; neg_seen = 0. All pipeline valids, counters and accumulators clear.
- Reset mid-block or while RESULT is pending discards all partial or unaccepted results. No output pulse follows.
- Latency: last pair accepted at edge t → S1 at t, S2 at t+1, accumulate at t+2, out_valid high from t+2 (visible after edge t+2).
- Throughput: one pair per cycle within a block. Inter-block bubble is a minimum of 3 cycles (pipeline drain + result handshake) when out_ready is held high.
- out_valid, once high, stays high with stable data until out_ready is sampled high.
- in_ready returns high the cycle after the result handshake edge.

## Structure
- Shared package quant_pkg: QUANT_WIDTH = 32 default, plus the accumulator-width function acc_width(width, len). Shared with the quantizer family.
- One sub-module, quant_err_sq: the two-stage abs-diff/square pipeline with valid passthrough. The FSM, counters and accumulators stay in the top.

## Test plan
- BLOCK_LEN=4; 4 pairs y=0x12345678, y_hat=0x12000000 back-to-back, out_ready=1 → one out_valid pulse at t+2 with sse=47059819520256, max_err=0x00345678, neg_seen=0.
- BLOCK_LEN=4; pairs (5,5),(0,1),(10,7),(7,10) → sse=19, max_err=3, neg_seen=1.
- BLOCK_LEN=4; 4 pairs y=0xFFFFFFFF, y_hat=0 → sse=4×0xFFFFFFFE00000001 exactly (ACC_W=66, no wrap), max_err=0xFFFFFFFF.
- Backpressure: out_ready=0 for 6 cycles after out_valid → in_ready=0 and outputs stable throughout. Raise out_ready → handshake, accumulators cleared, next block's sse independent of the previous one.
- Gapped input: in_valid toggled 1/0 with garbage data when low → result identical to back-to-back case.
- rst_n=0 for one cycle after 2 of 4 pairs → no out_valid. The next 4 pairs produce a result containing only those 4 samples.
